sdnet_event_bridge: RTL

SDNET_EVENT_BRIDGE -- requirements
Module: sdnet_event_bridge

---
 rtl/sdnet_bridge_pkg.sv | 14 +
 rtl/sdnet_evt_fifo.sv | 55 +++++
 rtl/sdnet_event_bridge.sv | 113 +++++++++++
 3 files changed

// File: rtl/sdnet_bridge_pkg.sv
// Shared types and constants for the SDNet extern-event bridge.
package sdnet_bridge_pkg;

   typedef enum logic {
      SOP_START    = 1'b0,
      SOP_WAIT_EOP = 1'b1
   } sop_state_e;

   localparam int RESP_FIXED_LAT = 0;
   localparam int RESP_ON_DEQ    = 1;

   localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/sdnet_evt_fifo.sv
// Per-channel event FIFO: power-of-two depth, head shown combinationally, zeros when empty.
module sdnet_evt_fifo #(
   parameter int W     = 128,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en_i,
   input  logic [W-1:0]             wr_data_i,
   input  logic                     rd_en_i,
   output logic [W-1:0]             rd_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          empty;

   assign empty = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      case ({wr_en_i, rd_en_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage carries no reset; the empty gate below keeps stale data off the output.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   assign rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
   assign count_o   = cnt_q;
   assign full_o    = (cnt_q == FULL_CNT);

endmodule

// File: rtl/sdnet_event_bridge.sv
// Bridges SDNet extern events to per-channel host FIFOs, tracks packet starts for metadata strobes.
module sdnet_event_bridge
   import sdnet_bridge_pkg::*;
#(
   parameter int NUM_EVENTS = 3,
   parameter int EVT_W      = 128,
   parameter int FIFO_DEPTH = 4,
   parameter int RESP_MODE  = 0,
   parameter int RESP_LAT   = 1
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             pkt_in_valid,
   input  logic                             pkt_in_ready,
   input  logic                             pkt_in_last,
   output logic                             meta_in_valid,
   input  logic [NUM_EVENTS-1:0]            evt_in_valid,
   input  logic [NUM_EVENTS*EVT_W-1:0]      evt_in_data,
   output logic [NUM_EVENTS-1:0]            evt_out_valid,
   input  logic [NUM_EVENTS-1:0]            evt_out_ready,
   output logic [NUM_EVENTS*EVT_W-1:0]      evt_out_data,
   output logic [NUM_EVENTS-1:0]            evt_resp_valid,
   output logic [NUM_EVENTS*DROP_CNT_W-1:0] drop_count,
   output logic [NUM_EVENTS-1:0]            ovf_flag,
   input  logic [NUM_EVENTS-1:0]            ovf_clear
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   sop_state_e            sop_q;
   logic                  armed_q;
   logic [NUM_EVENTS-1:0] evt_en;

   // armed_q masks events on the first edge after reset release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sop_q   <= SOP_START;
         armed_q <= 1'b0;
      end else begin
         armed_q <= 1'b1;
         if (pkt_in_valid && pkt_in_ready) begin
            case (sop_q)
               SOP_START:    if (!pkt_in_last) sop_q <= SOP_WAIT_EOP;
               SOP_WAIT_EOP: if (pkt_in_last)  sop_q <= SOP_START;
               default:      sop_q <= SOP_START;
            endcase
         end
      end
   end

   assign meta_in_valid = reset & pkt_in_valid & pkt_in_ready & (sop_q == SOP_START);
   assign evt_en        = evt_in_valid & {NUM_EVENTS{armed_q}};

   for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_ch
      logic [CW-1:0]         cnt;
      logic                  full, deq, drop;
      logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
      logic                  ovf_q, ovf_d;

      assign deq  = (cnt != '0) & evt_out_ready[i];
      assign drop = evt_en[i] & full & ~deq;

      sdnet_evt_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk       (clock),
         .rst_n     (reset),
         .wr_en_i   (evt_en[i] & ~drop),
         .wr_data_i (evt_in_data[i*EVT_W +: EVT_W]),
         .rd_en_i   (deq),
         .rd_data_o (evt_out_data[i*EVT_W +: EVT_W]),
         .count_o   (cnt),
         .full_o    (full)
      );

      // A fresh overflow outranks a coincident clear.
      assign drop_cnt_d = (drop && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
      assign ovf_d      = (ovf_q & ~ovf_clear[i]) | drop;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
         end else begin
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
         end
      end

      assign evt_out_valid[i]                         = (cnt != '0);
      assign drop_count[i*DROP_CNT_W +: DROP_CNT_W]   = drop_cnt_q;
      assign ovf_flag[i]                              = ovf_q;

      if (RESP_MODE == RESP_ON_DEQ) begin : g_resp_deq
         logic resp_q;
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) resp_q <= 1'b0;
            else        resp_q <= deq;
         end
         assign evt_resp_valid[i] = resp_q;
      end else begin : g_resp_lat
         // Every accepted strobe is echoed, including ones the FIFO dropped.
         logic [RESP_LAT-1:0] vld_pipe_q;
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               vld_pipe_q <= '0;
            end else begin
               vld_pipe_q[0] <= evt_en[i];
               for (int k = 1; k < RESP_LAT; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
            end
         end
         assign evt_resp_valid[i] = vld_pipe_q[RESP_LAT-1];
      end
   end

endmodule
